pipeline_ctrl: RTL

Central stall/flush/halt sequencer for the 5-stage core (IF, ID, EX, MEM, WB).
- Detects load-use hazards against the EX-stage control_t and inserts one bubble.
- Squashes wrong-path instructions on a taken branch.
- Freezes the whole pipe while data memory is not ready.
- Drains the pipe after a HALT_TYPE instruction, then holds the core halted.
- Drives every pipeline-register enable/flush and the PC enable; keeps saturating performance counters.

---
 rtl/common_pkg.sv | 29 ++
 rtl/pipeline_ctrl_hazard_detect.sv | 22 ++
 rtl/pipeline_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/common_pkg.sv
// Shared core types: EX-stage control word, pipeline sequencer state and stage-control bundle.
package common_pkg;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [4:0] write_back_id;
  } control_t;

  typedef enum logic [1:0] {
    PC_RUN    = 2'd0,
    PC_DRAIN  = 2'd1,
    PC_HALTED = 2'd2
  } pipe_ctrl_state_t;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
  } stage_ctl_t;

  localparam int DRAIN_CYCLES_DEF = 3;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use hazard compare: ID source operands against the destination of a load sitting in EX.
module hazard_detect
  import common_pkg::*;
(
  input  logic [4:0] rs1,
  input  logic [4:0] rs2,
  input  logic       uses_rs1,
  input  logic       uses_rs2,
  input  control_t   ex_control,
  output logic       load_use
);

  logic hit_rs1;
  logic hit_rs2;

  assign hit_rs1  = uses_rs1 && (rs1 == ex_control.write_back_id);
  assign hit_rs2  = uses_rs2 && (rs2 == ex_control.write_back_id);
  // x0 is hardwired zero, so a load targeting it can never create a dependency
  assign load_use = ex_control.mem_read && (ex_control.write_back_id != 5'd0) &&
                    (hit_rs1 || hit_rs2);

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush/halt sequencer for the 5-stage core, with saturating performance counters.
//   state     | meaning
//   PC_RUN    | normal issue; branch flush, load-use bubble, halt acceptance
//   PC_DRAIN  | halt accepted, older instructions retiring, ID fed with bubbles
//   PC_HALTED | every stage frozen, left only through reset
module pipeline_ctrl
  import common_pkg::*;
#(
  parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_uses_rs1,
  input  logic             id_uses_rs2,
  input  logic             id_is_halt,
  input  control_t         ex_control,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             halted,
  output logic [CNT_W-1:0] load_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [CNT_W-1:0] freeze_cnt
);

  localparam int DW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  pipe_ctrl_state_t state, state_nxt;
  logic [DW-1:0]    drain_cnt, drain_nxt;
  stage_ctl_t       ctl;
  logic             freeze;
  logic             load_use;

  assign freeze = mem_req && !mem_ready;

  hazard_detect u_hazard (
    .rs1        (id_rs1),
    .rs2        (id_rs2),
    .uses_rs1   (id_uses_rs1),
    .uses_rs2   (id_uses_rs2),
    .ex_control (ex_control),
    .load_use   (load_use)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PC_RUN;
      drain_cnt <= '0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= drain_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    drain_nxt = drain_cnt;
    if (!freeze) begin
      case (state)
        PC_RUN: begin
          if (!ex_branch_taken && !load_use && id_is_halt) begin
            state_nxt = PC_DRAIN;
            drain_nxt = DW'(DRAIN_CYCLES);
          end
        end
        PC_DRAIN: begin
          drain_nxt = drain_cnt - DW'(1);
          if (drain_cnt == DW'(1)) state_nxt = PC_HALTED;
        end
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    ctl = '0;
    if (rst_n && !freeze) begin
      case (state)
        PC_RUN: begin
          if (ex_branch_taken) begin
            ctl = '1;
          end else if (load_use) begin
            ctl.id_ex_en    = 1'b1;
            ctl.ex_mem_en   = 1'b1;
            ctl.mem_wb_en   = 1'b1;
            ctl.id_ex_flush = 1'b1;
          end else if (id_is_halt) begin
            // halt travels on into EX as a no-op while IF/ID is bubbled behind it
            ctl.if_id_en    = 1'b1;
            ctl.id_ex_en    = 1'b1;
            ctl.ex_mem_en   = 1'b1;
            ctl.mem_wb_en   = 1'b1;
            ctl.if_id_flush = 1'b1;
          end else begin
            ctl.pc_en     = 1'b1;
            ctl.if_id_en  = 1'b1;
            ctl.id_ex_en  = 1'b1;
            ctl.ex_mem_en = 1'b1;
            ctl.mem_wb_en = 1'b1;
          end
        end
        PC_DRAIN: begin
          ctl.id_ex_en    = 1'b1;
          ctl.ex_mem_en   = 1'b1;
          ctl.mem_wb_en   = 1'b1;
          ctl.id_ex_flush = 1'b1;
        end
        default: ctl = '0;
      endcase
    end
  end

  assign pc_en       = ctl.pc_en;
  assign if_id_en    = ctl.if_id_en;
  assign id_ex_en    = ctl.id_ex_en;
  assign ex_mem_en   = ctl.ex_mem_en;
  assign mem_wb_en   = ctl.mem_wb_en;
  assign if_id_flush = ctl.if_id_flush;
  assign id_ex_flush = ctl.id_ex_flush;
  assign halted      = (state == PC_HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_stall_cnt <= '0;
      flush_cnt      <= '0;
      freeze_cnt     <= '0;
    end else if (state != PC_HALTED) begin
      if (freeze) begin
        if (freeze_cnt != {CNT_W{1'b1}}) freeze_cnt <= freeze_cnt + 1'b1;
      end else if (state == PC_RUN) begin
        if (ex_branch_taken) begin
          if (flush_cnt != {CNT_W{1'b1}}) flush_cnt <= flush_cnt + 1'b1;
        end else if (load_use) begin
          if (load_stall_cnt != {CNT_W{1'b1}}) load_stall_cnt <= load_stall_cnt + 1'b1;
        end
      end
    end
  end

endmodule
